// File: rtl/photodiode_scanner.sv
// photodiode_scanner: debounces N photodiode beams into channel/edge events,
// queues them in a FIFO and exposes them over an Avalon-MM slave with a level irq.
module photodiode_scanner #(
    parameter int NUM_CHANNELS    = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 16,
    parameter bit BEAM_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] photodiode_in,
    input  logic [1:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic                    irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;

    logic [NUM_CHANNELS-1:0] sync1, sync2, brk, db, flip, pend, pend_edge, clr, mask;
    logic [CW-1:0]           cnt [NUM_CHANNELS];
    logic [4:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [FW-1:0]           count;
    logic                    enable, irq_en, overflow;
    logic                    found, sel_edge, full, push, pop, wr_ctl, flush;
    logic [3:0]              sel;
    logic [4:0]              head;
    logic [31:0]             rdata;
    logic                    unused_wd;

    assign unused_wd = ^avs_writedata;
    assign brk    = BEAM_ACTIVE_LOW ? ~sync2 : sync2;
    assign full   = count == FW'(FIFO_DEPTH);
    assign wr_ctl = avs_write && avs_address == 2'd2;
    assign flush  = wr_ctl && avs_writedata[2];
    assign push   = found && !full && !flush;
    assign pop    = avs_read && avs_address == 2'd1 && count != '0;
    assign head   = mem[rd_ptr];

    // Flip detection and lowest-index pending arbitration
    always_comb begin
        flip     = '0;
        clr      = '0;
        found    = 1'b0;
        sel      = '0;
        sel_edge = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            flip[i] = enable && brk[i] != db[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
            if (pend[i] && !found) begin
                found    = 1'b1;
                sel      = 4'(i);
                sel_edge = pend_edge[i];
                clr[i]   = 1'b1;
            end
        end
    end

    always_comb begin
        rdata = avs_address == 2'd0 ? (32'(db) | (32'(count) << 16))
              : avs_address == 2'd1 ? (count != '0 ? {1'b1, 22'b0, head[0], 4'b0, head[4:1]} : 32'd0)
              : avs_address == 2'd2 ? {23'b0, overflow, 6'b0, irq_en, enable}
              : 32'(mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= {NUM_CHANNELS{BEAM_ACTIVE_LOW}};
            sync2        <= {NUM_CHANNELS{BEAM_ACTIVE_LOW}};
            db           <= '0;
            pend         <= '0;
            pend_edge    <= '0;
            mask         <= '1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            enable       <= 1'b0;
            irq_en       <= 1'b0;
            overflow     <= 1'b0;
            avs_readdata <= '0;
            irq          <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= photodiode_in;
            sync2 <= sync1;
            db    <= db ^ flip;
            for (int i = 0; i < NUM_CHANNELS; i++)
                cnt[i] <= (!enable || brk[i] == db[i] || flip[i]) ? '0 : cnt[i] + 1'b1;
            pend      <= flush ? '0 : (pend & ~clr) | (flip & mask);
            pend_edge <= (pend_edge & ~flip) | (flip & brk);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= {sel, sel_edge};
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + FW'(push) - FW'(pop);
            end
            // A drop wins over a simultaneous software clear so no loss goes unreported
            if (found && full && !flush) overflow <= 1'b1;
            else if (wr_ctl && avs_writedata[8]) overflow <= 1'b0;
            if (wr_ctl) begin
                enable <= avs_writedata[0];
                irq_en <= avs_writedata[1];
            end
            if (avs_write && avs_address == 2'd3) mask <= avs_writedata[NUM_CHANNELS-1:0];
            if (avs_read) avs_readdata <= rdata;
            irq <= irq_en && count != '0;
        end
    end
endmodule

// File: doc/photodiode_scanner.md
# photodiode_scanner

Parametrised N-channel beam-break scanner for the laser harp: synchronises and debounces the photodiode inputs, converts debounced transitions into channel/edge events, queues them in a FIFO and presents them to the HPS over an Avalon-MM slave with a level interrupt. It sits between the photodiode conduit pins and the HPS lightweight bridge. It generalises the fixed 8-input photodiode export with a configurable channel count, debounce time, polarity, a per-channel mask and an event queue.

## Interface
- NUM_CHANNELS, 8, number of photodiode inputs (1..16)
- DEBOUNCE_CYCLES, 50000, stable-input cycles before a state change is accepted (must be >= NUM_CHANNELS + 2)
- FIFO_DEPTH, 16, event FIFO entries (power of 2, >= 2)
- BEAM_ACTIVE_LOW, 1, 1: input low means beam broken; 0: input high means broken

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- photodiode_in  in  NUM_CHANNELS  raw asynchronous photodiode levels
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- irq  out  1  level interrupt, registered

## Operation
- Input path: per channel 2-flop synchroniser, then polarity normalisation (broken = 1).
- Debounce: per-channel counter, width ceil(log2(DEBOUNCE_CYCLES))+1. Synchronised value != debounced state: counter increments; on reaching DEBOUNCE_CYCLES-1 while still different, the debounced state flips, the counter clears and an event is raised. Value == debounced state: counter clears.
- Event: {channel, edge}, edge 1 = broken (note on), 0 = restored (note off). An event raised on a channel with mask bit 0 is discarded; debounced state still tracks.
- Pending/arbiter: each raised event sets a per-channel pending flag + edge bit. Each cycle the lowest-index pending channel is pushed into the FIFO and its flag cleared. FIFO full: push dropped, pending flag cleared, OVERFLOW set (sticky).
- ENABLE=0: counters held at 0, debounced state frozen, no events raised; pending flags and FIFO untouched.
- Registers:
  - 0 STATUS (RO): [NUM_CHANNELS-1:0] debounced broken state; [20:16] FIFO count.
  - 1 EVENT (RO, read pops): bit31 valid, bit8 edge, [3:0] channel. Empty: returns 0, no pop.
  - 2 CONTROL (RW): bit0 ENABLE, bit1 IRQ_EN, bit2 FLUSH (write-1 empties FIFO, pending flags, reads 0), bit8 OVERFLOW (RO; write 1 to bit8 clears).
  - 3 MASK (RW): [NUM_CHANNELS-1:0] channel event enable; upper bits read 0.
- Unused bits read 0. Writes to RO registers ignored.
- irq = IRQ_EN & FIFO non-empty, registered.

## Timing
- Reset: avs_readdata 0, irq 0, debounced states 0 (not broken), counters 0, pending 0, FIFO empty, ENABLE 0, IRQ_EN 0, OVERFLOW 0, MASK all ones.
- Read latency 1: avs_read at cycle N, avs_readdata valid at N+1 and held until next read. EVENT pop takes effect at end of cycle N.
- Write takes effect at end of the write cycle.
- Input edge at cycle 0 (held stable, ENABLE=1): STATUS bit changes at 2+DEBOUNCE_CYCLES; event in FIFO at 3+DEBOUNCE_CYCLES (+k for k lower-index pending channels); irq high one cycle after FIFO non-empty.
- Simultaneous push and pop: both happen, count unchanged. Pop of last entry with no push: irq falls next cycle.
- FLUSH same cycle as a push: flush wins, FIFO empty.
- Glitch shorter than DEBOUNCE_CYCLES: no state change, no event.
- Reset mid-operation: all state returns to reset values next cycle regardless of bus activity.

## Test plan
- DEBOUNCE_CYCLES=4, ENABLE=1, IRQ_EN=1; drive ch3 low at cycle 0 -> STATUS[3]=1 at cycle 6, EVENT read returns 0x8000_0103, irq high then low after pop.
- ch0 and ch5 broken same cycle -> two events in order 0x8000_0100 then 0x8000_0105; STATUS count shows 2 then 1 then 0.
- 3-cycle low pulse on ch2 (DEBOUNCE_CYCLES=4) -> no STATUS change, FIFO count 0, irq stays 0.
- FIFO_DEPTH=4, generate 5 events without reading -> count 4, OVERFLOW=1; write CONTROL bit8=1 -> OVERFLOW=0; FLUSH -> count 0, EVENT read returns 0.
- MASK=0xFE, break ch0 -> STATUS[0]=1, no event; break ch1 -> event 0x8000_0101; restore ch1 -> event 0x8000_0001.
- Assert reset while FIFO holds 3 events and ch4 counter mid-count -> next cycle readdata 0, irq 0, count 0, MASK reads 0xFF, ENABLE 0.
